dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (processor load/store path) and port 1 (loader/debug port that preloads or inspects RAM).
- Grants one request at a time, using round-robin on contention.
- Drives the memory address, control and data, holds each access for a fixed latency, and returns read data with a one-cycle done pulse.
- Sits between the requesters and the data memory; it is the only block that drives the memory's control inputs.

---
 rtl/dmem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port round-robin arbiter in front of a single-port data memory.
// Optional macro DMEM_ARB_STATS_EN adds saturating per-port completed-transfer counters.
`default_nettype none

module dmem_port_arbiter #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [15:0]   stat0_cnt,
  output logic [15:0]   stat1_cnt
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [3:0]    lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          sel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      lat_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    re_d     = re_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie the port that did not finish last goes next.
          sel     = (r0_req && r1_req) ? ~last_q : r1_req;
          owner_d = sel;
          addr_d  = sel ? r1_addr : r0_addr;
          wdata_d = sel ? r1_wdata : r0_wdata;
          we_d    = sel ? r1_we : r0_we;
          re_d    = sel ? ~r1_we : ~r0_we;
          lat_d   = LAT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (lat_q == 4'd0) begin
          if (re_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          we_d    = 1'b0;
          re_d    = 1'b0;
          last_d  = owner_q;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign r0_gnt    = busy && !owner_q;
  assign r1_gnt    = busy && owner_q;
  assign r0_done   = (state_q == S_DONE) && !owner_q;
  assign r1_done   = (state_q == S_DONE) && owner_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat0_q, stat1_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat0_q <= 16'd0;
      stat1_q <= 16'd0;
    end else if (state_q == S_DONE) begin
      if (!owner_q) begin
        if (stat0_q != 16'hFFFF) stat0_q <= stat0_q + 16'd1;
      end else begin
        if (stat1_q != 16'hFFFF) stat1_q <= stat1_q + 16'd1;
      end
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`else
  assign stat0_cnt = 16'd0;
  assign stat1_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: MEM_LAT=1 and MEM_LAT=4 instances with a shared scoreboard.
`default_nettype none

module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        l1_r0_req, l1_r1_req, l4_r0_req;
  logic        r0_we, r1_we;
  logic [5:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;

  logic        l1_r0_gnt, l1_r0_done, l1_r1_gnt, l1_r1_done;
  logic [31:0] l1_r0_rdata, l1_r1_rdata, l1_mem_wdata, l1_mem_rdata;
  logic [5:0]  l1_mem_addr;
  logic        l1_mem_we, l1_mem_re, l1_busy;
  logic [15:0] l1_stat0, l1_stat1;

  logic        l4_r0_gnt, l4_r0_done, l4_r1_gnt, l4_r1_done;
  logic [31:0] l4_r0_rdata, l4_r1_rdata, l4_mem_wdata, l4_mem_rdata;
  logic [5:0]  l4_mem_addr;
  logic        l4_mem_we, l4_mem_re, l4_busy;
  logic [15:0] l4_stat0, l4_stat1;

  logic        bd_we1 = 1'b0, bd_we4 = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] ram1 [64];
  logic [31:0] ram4 [64];

  typedef struct packed {
    logic        inst;
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref1 [64];
  logic [31:0] ref4 [64];
  logic [31:0] mrd [4];
  int          checks = 0;
  int          failures = 0;

`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clock = ~clock;

  dmem_port_arbiter #(.AW(6), .DW(32), .MEM_LAT(1)) u_l1 (
    .clock(clock), .reset(reset),
    .r0_req(l1_r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(l1_r0_gnt), .r0_done(l1_r0_done), .r0_rdata(l1_r0_rdata),
    .r1_req(l1_r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(l1_r1_gnt), .r1_done(l1_r1_done), .r1_rdata(l1_r1_rdata),
    .mem_addr(l1_mem_addr), .mem_we(l1_mem_we), .mem_re(l1_mem_re),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy),
    .stat0_cnt(l1_stat0), .stat1_cnt(l1_stat1)
  );

  dmem_port_arbiter #(.AW(6), .DW(32), .MEM_LAT(4)) u_l4 (
    .clock(clock), .reset(reset),
    .r0_req(l4_r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(l4_r0_gnt), .r0_done(l4_r0_done), .r0_rdata(l4_r0_rdata),
    .r1_req(1'b0), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(l4_r1_gnt), .r1_done(l4_r1_done), .r1_rdata(l4_r1_rdata),
    .mem_addr(l4_mem_addr), .mem_we(l4_mem_we), .mem_re(l4_mem_re),
    .mem_wdata(l4_mem_wdata), .mem_rdata(l4_mem_rdata), .busy(l4_busy),
    .stat0_cnt(l4_stat0), .stat1_cnt(l4_stat1)
  );

  // Behavioural RAMs with combinational read and a backdoor preload port.
  always @(posedge clock) begin
    if (bd_we1) ram1[bd_addr] <= bd_data;
    else if (l1_mem_we) ram1[l1_mem_addr] <= l1_mem_wdata;
    if (bd_we4) ram4[bd_addr] <= bd_data;
    else if (l4_mem_we) ram4[l4_mem_addr] <= l4_mem_wdata;
  end
  assign l1_mem_rdata = l1_mem_re ? ram1[l1_mem_addr] : 32'h0;
  assign l4_mem_rdata = l4_mem_re ? ram4[l4_mem_addr] : 32'h0;

  // Scoreboard: every done pulse pops one expected completion.
  exp_t mon_e;
  always @(negedge clock) begin
    if (l1_r0_done || l1_r1_done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_l1 unexpected done actual_port=%0d required=none", l1_r1_done);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.inst !== 1'b0 || mon_e.port !== l1_r1_done || (l1_r0_done && l1_r1_done) ||
            mon_e.data !== (l1_r1_done ? l1_r1_rdata : l1_r0_rdata)) begin
          failures++;
          $display("FAIL sb_l1 actual port=%0d rdata=%h required inst=%0d port=%0d rdata=%h",
                   l1_r1_done, l1_r1_done ? l1_r1_rdata : l1_r0_rdata, mon_e.inst, mon_e.port, mon_e.data);
        end
      end
    end
    if (l4_r0_done || l4_r1_done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_l4 unexpected done actual_port=%0d required=none", l4_r1_done);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.inst !== 1'b1 || mon_e.port !== 1'b0 || l4_r1_done || mon_e.data !== l4_r0_rdata) begin
          failures++;
          $display("FAIL sb_l4 actual port=%0d rdata=%h required inst=%0d port=%0d rdata=%h",
                   l4_r1_done, l4_r0_rdata, mon_e.inst, mon_e.port, mon_e.data);
        end
      end
    end
  end

  function automatic void sb_push(input bit inst, input bit port, input logic we,
                                  input logic [5:0] a, input logic [31:0] d);
    exp_t e;
    e.inst = inst;
    e.port = port;
    if (we) begin
      if (inst) ref4[a] = d; else ref1[a] = d;
      e.data = mrd[{inst, port}];
    end else begin
      e.data = inst ? ref4[a] : ref1[a];
      mrd[{inst, port}] = e.data;
    end
    sb.push_back(e);
  endfunction

  task automatic assert_reset();
    reset = 1'b0;
    l1_r0_req = 1'b0; l1_r1_req = 1'b0; l4_r0_req = 1'b0;
    for (int i = 0; i < 4; i++) mrd[i] = 32'h0;
  endtask

  task automatic backdoor(input bit inst, input logic [5:0] a, input logic [31:0] d);
    @(negedge clock);
    bd_addr = a; bd_data = d;
    if (inst) begin bd_we4 = 1'b1; ref4[a] = d; end
    else      begin bd_we1 = 1'b1; ref1[a] = d; end
    @(negedge clock);
    bd_we1 = 1'b0; bd_we4 = 1'b0;
  endtask

  task automatic xfer_l1(input bit port, input logic we, input logic [5:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(negedge clock);
    if (port) begin l1_r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
    else      begin l1_r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
    sb_push(1'b0, port, we, a, d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (port ? l1_r1_done : l1_r0_done) begin got = 1'b1; break; end
    end
    if (port) l1_r1_req = 1'b0; else l1_r0_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL xfer_timeout port=%0d actual_done=0 required=1", port);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    r0_we = 1'b0; r1_we = 1'b0; r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    #1;
    checks++;
    if ({l1_r0_gnt, l1_r1_gnt, l1_r0_done, l1_r1_done, l1_mem_we, l1_mem_re, l1_busy,
         l1_mem_addr, l1_mem_wdata, l1_r0_rdata, l1_r1_rdata, l1_stat0, l1_stat1} !== '0) begin
      failures++;
      $display("FAIL reset_l1 actual gnt=%b%b busy=%b addr=%h rdata0=%h rdata1=%h required all zero",
               l1_r0_gnt, l1_r1_gnt, l1_busy, l1_mem_addr, l1_r0_rdata, l1_r1_rdata);
    end
    checks++;
    if ({l4_r0_gnt, l4_r1_gnt, l4_r0_done, l4_r1_done, l4_mem_we, l4_mem_re, l4_busy,
         l4_mem_addr, l4_mem_wdata, l4_r0_rdata, l4_r1_rdata, l4_stat0, l4_stat1} !== '0) begin
      failures++;
      $display("FAIL reset_l4 actual gnt=%b%b busy=%b addr=%h required all zero",
               l4_r0_gnt, l4_r1_gnt, l4_busy, l4_mem_addr);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_read_single();
    bit r1_quiet = 1'b1;
    backdoor(1'b0, 6'd3, 32'd4);
    l1_r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'd3;
    sb_push(1'b0, 1'b0, 1'b0, 6'd3, 32'h0);
    @(negedge clock);
    checks++;
    if ({l1_r0_gnt, l1_mem_re, l1_mem_we, l1_mem_addr, l1_r0_done} !== {1'b1, 1'b1, 1'b0, 6'd3, 1'b0}) begin
      failures++;
      $display("FAIL read_access actual gnt=%b re=%b we=%b addr=%0d done=%b required 1 1 0 3 0",
               l1_r0_gnt, l1_mem_re, l1_mem_we, l1_mem_addr, l1_r0_done);
    end
    if ({l1_r1_gnt, l1_r1_done, l1_r1_rdata} !== '0) r1_quiet = 1'b0;
    @(negedge clock);
    checks++;
    if ({l1_r0_done, l1_r0_gnt, l1_mem_re, l1_r0_rdata} !== {1'b1, 1'b1, 1'b0, 32'd4}) begin
      failures++;
      $display("FAIL read_done actual done=%b gnt=%b re=%b rdata=%h required 1 1 0 00000004",
               l1_r0_done, l1_r0_gnt, l1_mem_re, l1_r0_rdata);
    end
    if ({l1_r1_gnt, l1_r1_done, l1_r1_rdata} !== '0) r1_quiet = 1'b0;
    l1_r0_req = 1'b0;
    @(negedge clock);
    checks++;
    if ({l1_r0_done, l1_r0_gnt, l1_busy, l1_r0_rdata} !== {1'b0, 1'b0, 1'b0, 32'd4}) begin
      failures++;
      $display("FAIL read_after actual done=%b gnt=%b busy=%b rdata=%h required 0 0 0 00000004",
               l1_r0_done, l1_r0_gnt, l1_busy, l1_r0_rdata);
    end
    if ({l1_r1_gnt, l1_r1_done, l1_r1_rdata} !== '0) r1_quiet = 1'b0;
    checks++;
    if (!r1_quiet) begin
      failures++;
      $display("FAIL read_r1_quiet actual=active required=all zero");
    end
  endtask

  task automatic test_write_readback();
    int  we_cnt = 0;
    bit  hold_ok = 1'b1;
    bit  got = 1'b0;
    l1_r1_req = 1'b1; r1_we = 1'b1; r1_addr = 6'd10; r1_wdata = 32'hDEADBEEF;
    sb_push(1'b0, 1'b1, 1'b1, 6'd10, 32'hDEADBEEF);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (l1_mem_we) begin
        we_cnt++;
        if (l1_mem_addr !== 6'd10 || l1_mem_wdata !== 32'hDEADBEEF || l1_mem_re !== 1'b0) hold_ok = 1'b0;
      end
      if (l1_r1_done) begin got = 1'b1; break; end
    end
    l1_r1_req = 1'b0;
    checks++;
    if (!got || we_cnt != 1 || !hold_ok) begin
      failures++;
      $display("FAIL write_pulse actual done=%b we_cycles=%0d hold_ok=%b required 1 1 1", got, we_cnt, hold_ok);
    end
    xfer_l1(1'b1, 1'b0, 6'd10, 32'h0);
    checks++;
    if (ram1[10] !== 32'hDEADBEEF || l1_r0_rdata !== 32'd4) begin
      failures++;
      $display("FAIL write_mem actual ram10=%h r0_rdata=%h required deadbeef 00000004", ram1[10], l1_r0_rdata);
    end
  endtask

  task automatic test_contention();
    int   rise_cyc[4];
    logic [3:0] seq = '0;
    int   nr = 0, nd = 0;
    bit   both = 1'b0, gap_ok = 1'b1;
    logic p0 = 1'b0, p1 = 1'b0;
    assert_reset();
    backdoor(1'b0, 6'd5, 32'hAAAA0005);
    backdoor(1'b0, 6'd6, 32'hBBBB0006);
    r0_we = 1'b0; r0_addr = 6'd5; r1_we = 1'b0; r1_addr = 6'd6;
    l1_r0_req = 1'b1; l1_r1_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb_push(1'b0, 1'b0, 1'b0, 6'd5, 32'h0);
      sb_push(1'b0, 1'b1, 1'b0, 6'd6, 32'h0);
    end
    reset = 1'b1;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      @(negedge clock);
      if (l1_r0_gnt && l1_r1_gnt) both = 1'b1;
      if (nr < 4 && l1_r0_gnt && !p0) begin rise_cyc[nr] = c; seq[nr] = 1'b0; nr++; end
      else if (nr < 4 && l1_r1_gnt && !p1) begin rise_cyc[nr] = c; seq[nr] = 1'b1; nr++; end
      p0 = l1_r0_gnt; p1 = l1_r1_gnt;
      if (l1_r0_done || l1_r1_done) nd++;
    end
    l1_r0_req = 1'b0; l1_r1_req = 1'b0;
    for (int i = 0; i < 3; i++) if (i + 1 < nr && rise_cyc[i + 1] - rise_cyc[i] != 3) gap_ok = 1'b0;
    checks++;
    if (nr != 4 || nd != 4 || seq !== 4'b1010) begin
      failures++;
      $display("FAIL rr_order actual rises=%0d dones=%0d seq=%b required 4 4 1010", nr, nd, seq);
    end
    checks++;
    if (!gap_ok || both) begin
      failures++;
      $display("FAIL rr_spacing actual gap_ok=%b both_gnt=%b required 1 0", gap_ok, both);
    end
  endtask

  task automatic test_lat4();
    int  re_cnt = 0, done_k = 0;
    bit  addr_ok = 1'b1, quiet = 1'b1;
    backdoor(1'b1, 6'd7, 32'h12345678);
    l4_r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'd7;
    sb_push(1'b1, 1'b0, 1'b0, 6'd7, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (l4_mem_re) begin
        re_cnt++;
        if (l4_mem_addr !== 6'd7 || l4_mem_we !== 1'b0) addr_ok = 1'b0;
      end
      if ({l4_r1_gnt, l4_r1_done, l4_r1_rdata} !== '0) quiet = 1'b0;
      if (k == 2) r0_addr = 6'd9;
      if (l4_r0_done) begin done_k = k; break; end
    end
    l4_r0_req = 1'b0;
    checks++;
    if (done_k != 5 || re_cnt != 4) begin
      failures++;
      $display("FAIL lat4_timing actual done_cycle=%0d re_cycles=%0d required 5 4", done_k, re_cnt);
    end
    checks++;
    if (!addr_ok || !quiet) begin
      failures++;
      $display("FAIL lat4_hold actual addr_ok=%b r1_quiet=%b required 1 1", addr_ok, quiet);
    end
    checks++;
    if (l4_stat0 !== (STATS ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL lat4_stat actual=%0d required=%0d", l4_stat0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    backdoor(1'b0, 6'd20, 32'h00000055);
    l1_r0_req = 1'b1; r0_we = 1'b1; r0_addr = 6'd20; r0_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #2;
    checks++;
    if ({l1_mem_we, l1_r0_gnt, l1_busy} !== 3'b111) begin
      failures++;
      $display("FAIL mid_pre actual we=%b gnt=%b busy=%b required 1 1 1", l1_mem_we, l1_r0_gnt, l1_busy);
    end
    assert_reset();
    #1;
    checks++;
    if ({l1_mem_we, l1_r0_gnt, l1_busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_async actual we=%b gnt=%b busy=%b required 0 0 0", l1_mem_we, l1_r0_gnt, l1_busy);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (ram1[20] !== 32'h00000055) begin
      failures++;
      $display("FAIL mid_nowrite actual=%h required=00000055", ram1[20]);
    end
    r0_we = 1'b0; r0_addr = 6'd3; r1_we = 1'b0; r1_addr = 6'd10;
    l1_r0_req = 1'b1; l1_r1_req = 1'b1;
    sb_push(1'b0, 1'b0, 1'b0, 6'd3, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({l1_r0_gnt, l1_r1_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL mid_first_gnt actual r0=%b r1=%b required 1 0", l1_r0_gnt, l1_r1_gnt);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (l1_r0_done) begin got = 1'b1; break; end
    end
    l1_r0_req = 1'b0; l1_r1_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL mid_timeout actual_done=0 required=1");
    end
  endtask

  task automatic test_stats();
    assert_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer_l1(1'b0, 1'b0, 6'd3, 32'h0);
      if (i < 3) xfer_l1(1'b1, 1'b0, 6'd10, 32'h0);
    end
    @(negedge clock);
    checks++;
    if (l1_stat0 !== (STATS ? 16'd5 : 16'd0) || l1_stat1 !== (STATS ? 16'd3 : 16'd0)) begin
      failures++;
      $display("FAIL stats actual s0=%0d s1=%0d required %0d %0d",
               l1_stat0, l1_stat1, STATS ? 5 : 0, STATS ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_write_readback();
    test_contention();
    test_lat4();
    test_reset_mid();
    test_stats();
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual_pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
